// File: rtl/login_pkg.sv
// login_pkg: state encoding and fixed BCD credential table for the login authenticator
package login_pkg;
  typedef enum logic [2:0] {ID_ENTRY, ID_CHECK, PASS_ENTRY, PASS_CHECK, GRANTED, LOCKED} state_t;
  localparam int NUM_USERS = 4;
  localparam logic [NUM_USERS-1:0][15:0] USER_ID   = {16'h9090, 16'h1111, 16'h5678, 16'h1234};
  localparam logic [NUM_USERS-1:0][15:0] USER_PASS = {16'h0909, 16'h2222, 16'h4321, 16'h0000};
  function automatic logic [2:0] find_user(input logic [15:0] id);
    find_user = '0;
    for (int i = NUM_USERS - 1; i >= 0; i--)
      if (USER_ID[2'(i)] == id) find_user = {1'b1, 2'(i)};
  endfunction
endpackage

// File: rtl/login_digit_buffer.sv
// login_digit_buffer: 4-digit BCD shift register, newest digit in the low nibble
module login_digit_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [3:0]  digit_in,
  output logic [15:0] word,
  output logic [2:0]  count,
  output logic        full
);
  assign full = count == 3'd4;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      word  <= '0;
      count <= '0;
    end else if (clear) begin
      word  <= '0;
      count <= '0;
    end else if (load && !full) begin
      word  <= {word[11:0], digit_in};
      count <= count + 3'd1;
    end
endmodule

// File: rtl/login_authenticator.sv
// login_authenticator: collects BCD ID and password digits, checks the credential table, times lockout
module login_authenticator #(
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_id,
  input  logic       load_pass,
  input  logic       clear_session,
  input  logic [3:0] digit_in,
  output logic [3:0] user_id_digit1,
  output logic [3:0] user_id_digit2,
  output logic [3:0] user_id_digit3,
  output logic [3:0] user_id_digit4,
  output logic [1:0] user_index,
  output logic       user_found,
  output logic       access_granted,
  output logic       blink_pulse,
  output logic       out_of_attempts,
  output logic [1:0] attempts_left
);
  import login_pkg::*;
  localparam logic [1:0]  MAX_ATT   = 2'(MAX_ATTEMPTS);
  localparam logic [25:0] LOCK_LAST = 26'(LOCKOUT_CYCLES - 1);
  state_t      state, state_d;
  logic        id_q, pass_q, id_ld, pass_ld, id_clr, pass_clr, id_full, pass_full, id_hit;
  logic [15:0] id_word, pass_word;
  logic [2:0]  id_cnt, pass_cnt, hit;
  logic [25:0] lock_cnt, lock_cnt_d;
  logic        found_d, granted_d, blink_d, ooa_d;
  logic [1:0]  idx_d, att_d;
  assign id_ld   = load_id & ~id_q & (digit_in <= 4'd9) & (state == ID_ENTRY);
  assign pass_ld = load_pass & ~pass_q & (digit_in <= 4'd9) & (state == PASS_ENTRY);
  assign hit     = find_user(id_word);
  assign id_hit  = id_full & hit[2];
  assign {user_id_digit4, user_id_digit3, user_id_digit2, user_id_digit1} = id_word;
  login_digit_buffer u_id (
    .clk(clk), .rst(rst), .clear(id_clr), .load(id_ld), .digit_in(digit_in),
    .word(id_word), .count(id_cnt), .full(id_full)
  );
  login_digit_buffer u_pass (
    .clk(clk), .rst(rst), .clear(pass_clr), .load(pass_ld), .digit_in(digit_in),
    .word(pass_word), .count(pass_cnt), .full(pass_full)
  );
  always_comb begin
    state_d    = state;
    found_d    = user_found;
    idx_d      = user_index;
    granted_d  = access_granted;
    blink_d    = 1'b0;
    ooa_d      = out_of_attempts;
    att_d      = attempts_left;
    lock_cnt_d = lock_cnt;
    id_clr     = 1'b0;
    pass_clr   = 1'b0;
    case (state)
      ID_ENTRY:   state_d = (id_ld && id_cnt == 3'd3) ? ID_CHECK : ID_ENTRY;
      ID_CHECK: begin
        found_d = id_hit;
        idx_d   = id_hit ? hit[1:0] : user_index;
        id_clr  = ~id_hit;
        state_d = id_hit ? PASS_ENTRY : ID_ENTRY;
      end
      PASS_ENTRY: state_d = (pass_ld && pass_cnt == 3'd3) ? PASS_CHECK : PASS_ENTRY;
      PASS_CHECK:
        if (pass_full && pass_word == USER_PASS[user_index]) begin
          granted_d = 1'b1;
          state_d   = GRANTED;
        end else begin
          blink_d    = 1'b1;
          pass_clr   = 1'b1;
          att_d      = (attempts_left == 2'd0) ? 2'd0 : attempts_left - 2'd1;
          ooa_d      = att_d == 2'd0;
          lock_cnt_d = '0;
          state_d    = ooa_d ? LOCKED : PASS_ENTRY;
        end
      LOCKED:
        if (lock_cnt == LOCK_LAST) begin
          lock_cnt_d = '0;
          ooa_d      = 1'b0;
          att_d      = MAX_ATT;
          state_d    = PASS_ENTRY;
        end else
          lock_cnt_d = lock_cnt + 26'd1;
      default: ;
    endcase
    if (clear_session) begin
      state_d    = ID_ENTRY;
      found_d    = 1'b0;
      idx_d      = '0;
      granted_d  = 1'b0;
      blink_d    = 1'b0;
      ooa_d      = 1'b0;
      att_d      = MAX_ATT;
      lock_cnt_d = '0;
      id_clr     = 1'b1;
      pass_clr   = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state           <= ID_ENTRY;
      id_q            <= 1'b0;
      pass_q          <= 1'b0;
      user_found      <= 1'b0;
      user_index      <= '0;
      access_granted  <= 1'b0;
      blink_pulse     <= 1'b0;
      out_of_attempts <= 1'b0;
      attempts_left   <= MAX_ATT;
      lock_cnt        <= '0;
    end else begin
      state           <= state_d;
      id_q            <= load_id;
      pass_q          <= load_pass;
      user_found      <= found_d;
      user_index      <= idx_d;
      access_granted  <= granted_d;
      blink_pulse     <= blink_d;
      out_of_attempts <= ooa_d;
      attempts_left   <= att_d;
      lock_cnt        <= lock_cnt_d;
    end
endmodule

// File: tb/tb_login_authenticator.sv
// tb_login_authenticator: directed and randomized checks against a queue-based credential model
module tb_login_authenticator;
  localparam int L = 16, MAXA = 3;
  logic clk = 1'b0, rst = 1'b0, load_id = 1'b0, load_pass = 1'b0, clear_session = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic [3:0] d1, d2, d3, d4;
  logic [1:0] user_index, attempts_left;
  logic user_found, access_granted, blink_pulse, out_of_attempts;
  int total = 0, bad = 0;
  login_authenticator #(.MAX_ATTEMPTS(MAXA), .LOCKOUT_CYCLES(L)) dut (
    .clk(clk), .rst(rst), .load_id(load_id), .load_pass(load_pass),
    .clear_session(clear_session), .digit_in(digit_in),
    .user_id_digit1(d1), .user_id_digit2(d2), .user_id_digit3(d3), .user_id_digit4(d4),
    .user_index(user_index), .user_found(user_found), .access_granted(access_granted),
    .blink_pulse(blink_pulse), .out_of_attempts(out_of_attempts), .attempts_left(attempts_left)
  );
  always #5 clk = ~clk;
  int ids[4] = '{'h1234, 'h5678, 'h1111, 'h9090};
  int pws[4] = '{'h0000, 'h4321, 'h2222, 'h0909};
  int id_q[$], pw_q[$];
  bit m_found, m_granted, m_blink, m_ooa, m_id_pend, m_pw_pend, m_lid, m_lpw;
  int m_idx, m_att, m_lock;
  function automatic int join_bcd(input int q[$]);
    int v = 0;
    foreach (q[i]) v = v * 16 + q[i];
    return v;
  endfunction
  function automatic int id_digit(input int k);
    return (id_q.size() >= k) ? id_q[id_q.size() - k] : 0;
  endfunction
  function automatic void m_clear();
    id_q.delete();
    pw_q.delete();
    m_found = 0; m_granted = 0; m_blink = 0; m_ooa = 0;
    m_id_pend = 0; m_pw_pend = 0; m_idx = 0; m_att = MAXA; m_lock = 0;
  endfunction
  function automatic void m_step();
    bit is, ps, ok;
    int hit;
    is = load_id && !m_lid;
    ps = load_pass && !m_lpw;
    ok = digit_in <= 4'd9;
    m_lid = load_id;
    m_lpw = load_pass;
    m_blink = 0;
    if (clear_session) m_clear();
    else if (m_id_pend) begin
      m_id_pend = 0;
      hit = -1;
      for (int i = 3; i >= 0; i--) if (ids[i] == join_bcd(id_q)) hit = i;
      if (hit >= 0) begin m_found = 1; m_idx = hit; end
      else id_q.delete();
    end else if (m_pw_pend) begin
      m_pw_pend = 0;
      if (join_bcd(pw_q) == pws[m_idx]) m_granted = 1;
      else begin
        m_blink = 1;
        pw_q.delete();
        m_att--;
        if (m_att == 0) begin m_ooa = 1; m_lock = L; end
      end
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) begin m_ooa = 0; m_att = MAXA; end
    end else if (!m_granted) begin
      if (!m_found) begin
        if (is && ok) begin id_q.push_back(int'(digit_in)); m_id_pend = id_q.size() == 4; end
      end else if (ps && ok) begin
        pw_q.push_back(int'(digit_in));
        m_pw_pend = pw_q.size() == 4;
      end
    end
  endfunction
  always @(posedge clk or negedge rst)
    if (!rst) begin m_clear(); m_lid = 0; m_lpw = 0; end
    else m_step();
  task automatic chk(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (rst) begin
    chk("user_found", user_found, int'(m_found));
    chk("user_index", user_index, m_idx);
    chk("access_granted", access_granted, int'(m_granted));
    chk("blink_pulse", blink_pulse, int'(m_blink));
    chk("out_of_attempts", out_of_attempts, int'(m_ooa));
    chk("attempts_left", attempts_left, m_att);
    chk("digit1", d1, id_digit(1));
    chk("digit2", d2, id_digit(2));
    chk("digit3", d3, id_digit(3));
    chk("digit4", d4, id_digit(4));
  end
  task automatic sync();
    @(posedge clk);
    #2;
  endtask
  task automatic press(input bit i, input bit p, input logic [3:0] d, input int hold);
    digit_in = d;
    load_id = i;
    load_pass = p;
    repeat (hold) @(posedge clk);
    #2;
    load_id = 0;
    load_pass = 0;
    sync();
  endtask
  task automatic enter(input bit is_id, input int val);
    for (int k = 3; k >= 0; k--) press(is_id, !is_id, 4'((val >> (4 * k)) & 15), 1);
  endtask
  task automatic pulse_clear();
    clear_session = 1;
    sync();
    clear_session = 0;
    sync();
  endtask
  initial begin
    int r, tu, pos, dd, ch, hold;
    sync();
    chk("reset found", user_found, 0);
    chk("reset attempts", attempts_left, 3);
    chk("reset digit1", d1, 0);
    rst = 1;
    sync();
    enter(1, 'h1234);
    chk("t1 found", user_found, 1);
    chk("t1 index", user_index, 0);
    chk("t1 digit1", d1, 4);
    chk("t1 digit4", d4, 1);
    enter(0, 'h0000);
    chk("t1 granted", access_granted, 1);
    pulse_clear();
    enter(1, 'h5678);
    for (int a = 2; a >= 0; a--) begin
      enter(0, 'h1111);
      chk("t2 blink", blink_pulse, 1);
      chk("t2 attempts", attempts_left, a);
    end
    chk("t2 locked", out_of_attempts, 1);
    repeat (L - 1) @(posedge clk);
    #2;
    chk("t2 still locked", out_of_attempts, 1);
    sync();
    chk("t2 unlocked", out_of_attempts, 0);
    chk("t2 attempts restored", attempts_left, 3);
    chk("t2 found kept", user_found, 1);
    pulse_clear();
    enter(1, 'h9999);
    chk("t3 miss found", user_found, 0);
    chk("t3 miss digit1", d1, 0);
    enter(1, 'h1111);
    chk("t3 found", user_found, 1);
    chk("t3 index", user_index, 2);
    pulse_clear();
    press(1, 0, 4'd7, 20);
    chk("t4 held digit1", d1, 7);
    chk("t4 held digit2", d2, 0);
    press(1, 0, 4'd12, 1);
    chk("t4 invalid digit1", d1, 7);
    chk("t4 invalid digit2", d2, 0);
    pulse_clear();
    enter(1, 'h5678);
    repeat (3) enter(0, 'h0000);
    chk("t5 locked", out_of_attempts, 1);
    clear_session = 1;
    sync();
    chk("t5 clr ooa", out_of_attempts, 0);
    chk("t5 clr attempts", attempts_left, 3);
    chk("t5 clr found", user_found, 0);
    clear_session = 0;
    sync();
    enter(1, 'h1234);
    enter(0, 'h0000);
    chk("t5 granted", access_granted, 1);
    clear_session = 1;
    sync();
    chk("t5 clr granted", access_granted, 0);
    chk("t5 clr found2", user_found, 0);
    clear_session = 0;
    sync();
    enter(1, 'h1234);
    press(0, 1, 4'd0, 1);
    press(0, 1, 4'd0, 1);
    rst = 0;
    #1;
    chk("t6 async found", user_found, 0);
    chk("t6 async digit1", d1, 0);
    chk("t6 async attempts", attempts_left, 3);
    sync();
    rst = 1;
    sync();
    enter(1, 'h1234);
    chk("t6 reentry found", user_found, 1);
    enter(0, 'h0000);
    chk("t6 reentry granted", access_granted, 1);
    pulse_clear();
    tu = 0;
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 3 || (m_granted && r < 30)) pulse_clear();
      else if (r < 6) repeat ($urandom_range(1, 4)) sync();
      else begin
        if (!m_found && id_q.size() == 0) tu = $urandom_range(0, 3);
        if (!m_found) begin
          pos = id_q.size() & 3;
          dd = ($urandom_range(0, 9) < 8) ? (ids[tu] >> (4 * (3 - pos))) & 15 : $urandom_range(0, 15);
        end else begin
          pos = pw_q.size() & 3;
          dd = ($urandom_range(0, 1) == 1) ? (pws[m_idx] >> (4 * (3 - pos))) & 15 : $urandom_range(0, 15);
        end
        ch = $urandom_range(0, 19);
        hold = $urandom_range(1, 3);
        if (ch == 0) press(1, 1, 4'(dd), hold);
        else if (ch == 1) press(m_found, !m_found, 4'(dd), hold);
        else press(!m_found, m_found, 4'(dd), hold);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
